mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  - MEM-stage load/store unit of the 64-bit RV pipeline. Consumes the EX/MEM register outputs:
//    control bits, ALU address, store data and rs2 index.
//  - Drives a request/acknowledge data-memory bus and stalls the pipeline while an access is outstanding.
//  - Returns sign- or zero-extended load data to the MEM/WB register.
//  - Forwards WB-stage results into store data when RegRs2_mem matches rd_wb.
// PARAMETERS
//  - XLEN   64  datapath / address width
//  - BE_W    8  byte enables per bus beat (XLEN/8)
// PORTS
//  clk              in   1     clock
//  rst              in   1     reset; synchronous, active-high
//  memread_mem      in   1     load in MEM stage
//  memwrite_mem     in   1     store in MEM stage
//  funct3_mem       in   3     size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//  alu_result_mem   in   XLEN  effective byte address
//  writedata_mem    in   XLEN  store data from EX/MEM
//  RegRs2_mem       in   5     rs2 index of the store
//  regwrite_wb      in   1     WB stage writes the register file
//  rd_wb            in   5     WB destination register
//  wb_data          in   XLEN  WB write-back value
//  dmem_req         out  1     bus request, held until ack
//  dmem_we          out  1     1 = write beat
//  dmem_addr        out  XLEN  doubleword-aligned address ({addr[63:3],3'b000})
//  dmem_wdata       out  XLEN  lane-replicated store data
//  dmem_be          out  BE_W  byte enables
//  dmem_ack         in   1     bus acknowledge; dmem_rdata valid this cycle on reads
//  dmem_rdata       in   XLEN  read doubleword
//  stall_mem        out  1     freeze PC, IF/ID, ID/EX, EX/MEM
//  readdata_mem     out  XLEN  extended load result
//  readdata_valid   out  1     one-cycle pulse with readdata_mem
// BEHAVIOUR
//  - Reset: state IDLE. All bus outputs, stall_mem, readdata_mem and readdata_valid are 0.
//    Reset mid-access drops dmem_req next edge; a late dmem_ack is ignored.
//  - Access = memread_mem | memwrite_mem.
//    If both are set, treat as a store; readdata_valid stays 0.
//  - FSM:
//    - IDLE -> REQ on access.
//      - Latch address, funct3, dir, be, wdata.
//      - stall_mem=1, combinational in IDLE.
//    - REQ: dmem_req=1, registered, outputs stable.
//      - dmem_ack -> DONE; loads capture the extended rdata into readdata_mem.
//      - No ack -> stay in REQ; stall_mem=1.
//    - DONE: stall_mem=0, dmem_req=0, readdata_valid=1 for loads; -> IDLE unconditionally.
//  - Latency: minimum 2 stall cycles when ack arrives in the first REQ cycle (access->DONE = 2 cycles).
//    Each extra bus wait adds one cycle.
//  - No access in IDLE: stall_mem=0, zero-cycle pass-through.
//  - Store-data forwarding is evaluated once, in IDLE:
//    - Use wb_data if regwrite_wb && rd_wb!=0 && rd_wb==RegRs2_mem; else writedata_mem.
//    - The latched value is not re-evaluated during the stall.
//  - Lanes, with off = addr[2:0]:
//    - Stores: B replicated x8, be=8'h01<<off; H x4, be=8'h03<<off; W x2, be=8'h0F<<off; D be=8'hFF.
//    - Loads: shift rdata right by off*8, then sign-extend (B/H/W) or zero-extend (BU/HU/WU); D is unmodified.
//    - Reads always drive be=8'hFF.
//  - Misaligned handling (without macro): off is masked to size alignment before lane selection.
//    - Mask: H clears bit0, W clears bits[1:0], D clears all.
//    - The access never crosses a doubleword.
//  - readdata_mem holds its last value between loads.
// CONFIGURATION
//  - MEM_MISALIGN_TRAP_EN defined:
//    - Extra port misalign_exc (out, 1).
//    - A misaligned H/W/D access in IDLE does not enter REQ: no bus request, stall_mem=0.
//    - misalign_exc pulses 1 for that cycle; readdata_valid stays 0.
//  - MEM_MISALIGN_TRAP_EN undefined: port absent; masking rule above applies.
// TESTING
//  - LD at 0x1000, ack 1st REQ cycle, rdata=0x1122334455667788:
//    stall 2 cycles, readdata_mem=0x1122334455667788, readdata_valid 1 cycle.
//  - LB at 0x1003, rdata byte3=0x80:
//    readdata_mem=0xFFFFFFFFFFFFFF80; LBU gives 0x80.
//  - SH at 0x2006, data 0xBEEF, ack after 3 wait cycles:
//    dmem_be=0xC0, dmem_wdata=0xBEEFBEEFBEEFBEEF, req held 4 cycles, stall 5 cycles.
//  - SD with RegRs2_mem=5, rd_wb=5, regwrite_wb=1, wb_data=0xA5A5:
//    dmem_wdata=0xA5A5; with rd_wb=0, writedata_mem is used instead.
//  - rst asserted in REQ: next cycle dmem_req=0, stall_mem=0, state IDLE; an ack one cycle later is ignored.
//  - MEM_MISALIGN_TRAP_EN, LW at 0x3002:
//    no dmem_req, misalign_exc=1 one cycle, stall_mem=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for the 64-bit RV pipeline.
// Issues one request/acknowledge data-memory access per load or store and
// stalls the pipeline while it is outstanding. It forwards the WB result
// into the store data, replicates store data across the byte lanes, and
// returns sign- or zero-extended load data.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, a
// misaligned H/W/D access raises misalign_exc instead of going to the bus.
// When it is undefined, the byte offset is masked to the access size.
module mem_access_unit #(
    parameter int XLEN = 64,
    parameter int BE_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memread_mem,
    input  logic            memwrite_mem,
    input  logic [2:0]      funct3_mem,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] writedata_mem,
    input  logic [4:0]      RegRs2_mem,
    input  logic            regwrite_wb,
    input  logic [4:0]      rd_wb,
    input  logic [XLEN-1:0] wb_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [BE_W-1:0] dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall_mem,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            misalign_exc,
`endif
    output logic [XLEN-1:0] readdata_mem,
    output logic            readdata_valid
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state_reg;
    logic [2:0]      off_reg;
    logic [2:0]      funct3_reg;
    logic            load_reg;

    logic            access;
    logic            start;
    logic [2:0]      off_raw;
    logic [2:0]      off_next;
    logic [XLEN-1:0] fwd_data;
    logic [XLEN-1:0] wdata_next;
    logic [BE_W-1:0] be_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign access  = memread_mem | memwrite_mem;
    assign off_raw = alu_result_mem[2:0];

    // Size-align the byte offset so an access never crosses a doubleword
    always_comb begin
        off_next = off_raw;
        case (funct3_mem[1:0])
            2'b00:   off_next = off_raw;
            2'b01:   off_next = {off_raw[2:1], 1'b0};
            2'b10:   off_next = {off_raw[2], 2'b00};
            default: off_next = 3'b000;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned   = (off_next != off_raw);
    assign start        = access & ~misaligned;
    assign misalign_exc = (state_reg == IDLE) & access & misaligned;
`else
    assign start = access;
`endif

    // The pipeline is frozen from the first IDLE cycle of an access until DONE
    assign stall_mem = ((state_reg == IDLE) & start) | (state_reg == REQ);

    // WB-stage forwarding of store data; x0 is never forwarded
    assign fwd_data = (regwrite_wb && (rd_wb != 5'd0) && (rd_wb == RegRs2_mem))
                      ? wb_data : writedata_mem;

    // Replicate store data across the lanes and build the byte enables
    always_comb begin
        wdata_next = fwd_data;
        be_next    = '1;
        case (funct3_mem[1:0])
            2'b00: begin
                wdata_next = {8{fwd_data[7:0]}};
                be_next    = BE_W'(8'h01) << off_next;
            end
            2'b01: begin
                wdata_next = {4{fwd_data[15:0]}};
                be_next    = BE_W'(8'h03) << off_next;
            end
            2'b10: begin
                wdata_next = {2{fwd_data[31:0]}};
                be_next    = BE_W'(8'h0F) << off_next;
            end
            default: begin
                wdata_next = fwd_data;
                be_next    = '1;
            end
        endcase
    end

    // Align the addressed lane to bit 0 and extend it according to the latched funct3
    assign shifted = dmem_rdata >> {off_reg, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (funct3_reg)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    // Access FSM: latch the request in IDLE, hold it in REQ until ack, then retire in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            off_reg        <= 3'b000;
            funct3_reg     <= 3'b000;
            load_reg       <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_be        <= '0;
            readdata_mem   <= '0;
            readdata_valid <= 1'b0;
        end else begin
            readdata_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= REQ;
                        off_reg    <= off_next;
                        funct3_reg <= funct3_mem;
                        load_reg   <= ~memwrite_mem;
                        dmem_req   <= 1'b1;
                        dmem_we    <= memwrite_mem;
                        dmem_addr  <= {alu_result_mem[XLEN-1:3], 3'b000};
                        dmem_wdata <= memwrite_mem ? wdata_next : '0;
                        dmem_be    <= memwrite_mem ? be_next : '1;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state_reg <= DONE;
                        dmem_req  <= 1'b0;
                        if (load_reg) begin
                            readdata_mem   <= load_ext;
                            readdata_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// A small bus responder acknowledges after a chosen number of wait cycles.
// It also models the pipeline, which holds the EX/MEM inputs while stall_mem is high.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        memread_mem, memwrite_mem;
    logic [2:0]  funct3_mem;
    logic [63:0] alu_result_mem, writedata_mem, wb_data;
    logic [4:0]  RegRs2_mem, rd_wb;
    logic        regwrite_wb;
    logic        dmem_req, dmem_we, dmem_ack, stall_mem, readdata_valid;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata, readdata_mem;
    logic [7:0]  dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Results measured by run_access
    int          m_stall, m_req, m_valid;
    logic        m_done, m_we;
    logic [63:0] m_rd, m_addr, m_wdata;
    logic [7:0]  m_be;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .memread_mem(memread_mem), .memwrite_mem(memwrite_mem),
        .funct3_mem(funct3_mem), .alu_result_mem(alu_result_mem),
        .writedata_mem(writedata_mem), .RegRs2_mem(RegRs2_mem),
        .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .wb_data(wb_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc(misalign_exc),
`endif
        .readdata_mem(readdata_mem), .readdata_valid(readdata_valid)
    );

    task automatic clear_inputs();
        memread_mem = 0; memwrite_mem = 0; funct3_mem = 0;
        alu_result_mem = 0; writedata_mem = 0; RegRs2_mem = 0;
        regwrite_wb = 0; rd_wb = 0; wb_data = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Drive one access and hold it while stalled. Ack after 'waits' REQ cycles.
    // If mod_wb is set, wb_data changes during the stall.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wd,
                              input logic [4:0] rs2, input logic rwb, input logic [4:0] rdwb,
                              input logic [63:0] wbd, input int waits,
                              input logic [63:0] rdata, input logic mod_wb);
        m_stall = 0; m_req = 0; m_valid = 0; m_done = 0;
        m_rd = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
        @(posedge clk); #1;
        memread_mem = rd; memwrite_mem = wr; funct3_mem = f3;
        alu_result_mem = addr; writedata_mem = wd; RegRs2_mem = rs2;
        regwrite_wb = rwb; rd_wb = rdwb; wb_data = wbd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (readdata_valid) begin m_valid++; m_rd = readdata_mem; end
            if (dmem_req) begin
                m_req++;
                m_we = dmem_we; m_addr = dmem_addr; m_wdata = dmem_wdata; m_be = dmem_be;
                dmem_ack   = (m_req > waits);
                dmem_rdata = rdata;
                if (mod_wb) wb_data = 64'hDEAD_0000_DEAD_0000;
            end else begin
                dmem_ack = 0;
            end
            if (stall_mem) m_stall++;
            else begin m_done = 1; break; end
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        if (readdata_valid) m_valid++;
        $display("access rd=%0b wr=%0b f3=%0d addr=%h stall=%0d req=%0d valid=%0d be=%h wdata=%h rdata=%h",
                 rd, wr, f3, addr, m_stall, m_req, m_valid, m_be, m_wdata, m_rd);
        n_checks++;
        if (m_done !== 1'b1) begin
            n_fail++; $display("FAIL access_timeout: stall never released, required release within 40 cycles");
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, dmem_we, stall_mem, readdata_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {dmem_req, dmem_we, stall_mem, readdata_valid});
        end
        n_checks++;
        if ({dmem_addr, dmem_wdata, readdata_mem} !== '0 || dmem_be !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: addr=%h wdata=%h be=%h rd=%h required zeros", dmem_addr, dmem_wdata, dmem_be, readdata_mem);
        end
        $display("reset done");
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({stall_mem, dmem_req} !== 2'b00) begin
            n_fail++; $display("FAIL idle_passthrough: stall/req=%b required 00", {stall_mem, dmem_req});
        end
        $display("idle cycle stall=%0b req=%0b", stall_mem, dmem_req);
    endtask

    task automatic test_ld();
        run_access(1, 0, 3'b011, 64'h1000, 0, 0, 0, 0, 0, 0, 64'h1122334455667788, 0);
        n_checks++;
        if (m_stall !== 2) begin n_fail++; $display("FAIL ld_stall: got %0d required 2", m_stall); end
        n_checks++;
        if (m_rd !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_data: got %h required 1122334455667788", m_rd); end
        n_checks++;
        if (m_valid !== 1) begin n_fail++; $display("FAIL ld_valid: got %0d pulses required 1", m_valid); end
        n_checks++;
        if (m_be !== 8'hFF || m_addr !== 64'h1000 || m_we !== 1'b0) begin
            n_fail++; $display("FAIL ld_bus: be=%h addr=%h we=%b required ff 1000 0", m_be, m_addr, m_we);
        end
        n_checks++;
        if (readdata_mem !== 64'h1122334455667788) begin
            n_fail++; $display("FAIL ld_hold: got %h required 1122334455667788", readdata_mem);
        end
    endtask

    task automatic test_lb_lbu();
        run_access(1, 0, 3'b000, 64'h1003, 0, 0, 0, 0, 0, 0, 64'h1122334480667788, 0);
        n_checks++;
        if (m_rd !== 64'hFFFFFFFFFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h required ffffffffffffff80", m_rd); end
        n_checks++;
        if (m_addr !== 64'h1000) begin n_fail++; $display("FAIL lb_addr: got %h required 1000", m_addr); end
        run_access(1, 0, 3'b100, 64'h1003, 0, 0, 0, 0, 0, 0, 64'h1122334480667788, 0);
        n_checks++;
        if (m_rd !== 64'h80) begin n_fail++; $display("FAIL lbu_zext: got %h required 80", m_rd); end
    endtask

    task automatic test_lw_lwu_lh();
        run_access(1, 0, 3'b010, 64'h1004, 0, 0, 0, 0, 0, 1, 64'h8899AABB55667788, 0);
        n_checks++;
        if (m_rd !== 64'hFFFFFFFF8899AABB) begin n_fail++; $display("FAIL lw_sext: got %h required ffffffff8899aabb", m_rd); end
        n_checks++;
        if (m_stall !== 3) begin n_fail++; $display("FAIL lw_stall_1wait: got %0d required 3", m_stall); end
        run_access(1, 0, 3'b110, 64'h1004, 0, 0, 0, 0, 0, 0, 64'h8899AABB55667788, 0);
        n_checks++;
        if (m_rd !== 64'h8899AABB) begin n_fail++; $display("FAIL lwu_zext: got %h required 8899aabb", m_rd); end
`ifndef MEM_MISALIGN_TRAP_EN
        // Misaligned halfword at offset 5 is masked down to offset 4
        run_access(1, 0, 3'b001, 64'h1005, 0, 0, 0, 0, 0, 0, 64'h1122334455667788, 0);
        n_checks++;
        if (m_rd !== 64'h3344) begin n_fail++; $display("FAIL lh_mask: got %h required 3344", m_rd); end
`endif
    endtask

    task automatic test_sh_waits();
        run_access(0, 1, 3'b001, 64'h2006, 64'hBEEF, 0, 0, 0, 0, 3, 0, 0);
        n_checks++;
        if (m_be !== 8'hC0) begin n_fail++; $display("FAIL sh_be: got %h required c0", m_be); end
        n_checks++;
        if (m_wdata !== 64'hBEEFBEEFBEEFBEEF) begin n_fail++; $display("FAIL sh_wdata: got %h required beefbeefbeefbeef", m_wdata); end
        n_checks++;
        if (m_req !== 4 || m_stall !== 5) begin n_fail++; $display("FAIL sh_timing: req=%0d stall=%0d required 4 5", m_req, m_stall); end
        n_checks++;
        if (m_valid !== 0 || m_we !== 1'b1 || m_addr !== 64'h2000) begin
            n_fail++; $display("FAIL sh_bus: valid=%0d we=%b addr=%h required 0 1 2000", m_valid, m_we, m_addr);
        end
    endtask

    task automatic test_sb_sw();
        run_access(0, 1, 3'b000, 64'h13, 64'h12345678_9ABCDEAB, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (m_be !== 8'h08 || m_wdata !== 64'hABABABABABABABAB) begin
            n_fail++; $display("FAIL sb_lane: be=%h wdata=%h required 08 abababababababab", m_be, m_wdata);
        end
        run_access(0, 1, 3'b010, 64'h4004, 64'h12345678_CAFEF00D, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (m_be !== 8'hF0 || m_wdata !== 64'hCAFEF00DCAFEF00D) begin
            n_fail++; $display("FAIL sw_lane: be=%h wdata=%h required f0 cafef00dcafef00d", m_be, m_wdata);
        end
    endtask

    task automatic test_forwarding();
        run_access(0, 1, 3'b011, 64'h5000, 64'h1234, 5'd5, 1, 5'd5, 64'hA5A5, 2, 0, 1);
        n_checks++;
        if (m_wdata !== 64'hA5A5) begin n_fail++; $display("FAIL fwd_hit: got %h required a5a5", m_wdata); end
        n_checks++;
        if (m_be !== 8'hFF) begin n_fail++; $display("FAIL fwd_be: got %h required ff", m_be); end
        run_access(0, 1, 3'b011, 64'h5000, 64'h1234, 5'd0, 1, 5'd0, 64'hA5A5, 0, 0, 0);
        n_checks++;
        if (m_wdata !== 64'h1234) begin n_fail++; $display("FAIL fwd_x0: got %h required 1234", m_wdata); end
        run_access(0, 1, 3'b011, 64'h5000, 64'h1234, 5'd5, 0, 5'd5, 64'hA5A5, 0, 0, 0);
        n_checks++;
        if (m_wdata !== 64'h1234) begin n_fail++; $display("FAIL fwd_nowrite: got %h required 1234", m_wdata); end
    endtask

    task automatic test_read_and_write();
        run_access(1, 1, 3'b011, 64'h6000, 64'h77, 0, 0, 0, 0, 0, 64'hFFFF, 0);
        n_checks++;
        if (m_we !== 1'b1 || m_valid !== 0 || m_wdata !== 64'h77) begin
            n_fail++; $display("FAIL rw_is_store: we=%b valid=%0d wdata=%h required 1 0 77", m_we, m_valid, m_wdata);
        end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        memread_mem = 1; funct3_mem = 3'b011; alu_result_mem = 64'h7000;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b required 1", dmem_req); end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; clear_inputs();
        dmem_ack = 1; dmem_rdata = 64'h55;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, stall_mem} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_req: req/stall=%b required 00", {dmem_req, stall_mem});
        end
        @(posedge clk); #1 dmem_ack = 0;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, stall_mem, readdata_valid} !== 3'b000 || readdata_mem !== 64'h0) begin
            n_fail++; $display("FAIL rst_late_ack: req/stall/valid=%b rd=%h required 000 0",
                               {dmem_req, stall_mem, readdata_valid}, readdata_mem);
        end
        $display("reset mid-access req=%0b stall=%0b", dmem_req, stall_mem);
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        @(posedge clk); #1;
        memread_mem = 1; funct3_mem = 3'b010; alu_result_mem = 64'h3002;
        @(negedge clk);
        n_checks++;
        if ({misalign_exc, stall_mem, dmem_req} !== 3'b100) begin
            n_fail++; $display("FAIL trap_cycle: exc/stall/req=%b required 100", {misalign_exc, stall_mem, dmem_req});
        end
        @(posedge clk); #1 clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({misalign_exc, dmem_req, readdata_valid} !== 3'b000) begin
            n_fail++; $display("FAIL trap_after: exc/req/valid=%b required 000", {misalign_exc, dmem_req, readdata_valid});
        end
        $display("misaligned LW trapped");
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_ld();
        test_lb_lbu();
        test_lw_lwu_lh();
        test_sh_waits();
        test_sb_sw();
        test_forwarding();
        test_read_and_write();
        test_reset_mid_access();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign_trap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
